// File: rtl/fixed_pkg.sv
// -----------------------------------------------------------------------------
// fixed_pkg
// Shared Q8.24 fixed-point definitions for the divider, the multiplier and the
// network datapath.
//   WIDTH / FRAC : word width and number of fractional bits
//   N_ITER       : number of restoring iterations for one divide
//   fixed_t      : signed Q8.24 word
//   Q_MAX/Q_MIN  : saturation limits
//   div_state_t  : divider FSM states
// -----------------------------------------------------------------------------
package fixed_pkg;
   localparam int WIDTH  = 32;
   localparam int FRAC   = 24;
   localparam int N_ITER = WIDTH + FRAC;

   typedef logic signed [WIDTH-1:0] fixed_t;

   localparam fixed_t Q_MAX = 32'h7FFFFFFF;
   localparam fixed_t Q_MIN = 32'h80000000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } div_state_t;
endpackage

// File: rtl/fixed_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Combinational restoring-division cell: shifts the next dividend bit into the
// remainder and subtracts the divisor magnitude when it fits.
//   i_rem    : current remainder (WIDTH+1 bits)
//   i_bit    : next dividend bit, MSB first
//   i_b_mag  : divisor magnitude
//   o_rem    : updated remainder
//   o_q_bit  : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_b_mag,
   output logic [WIDTH:0]   o_rem,
   output logic             o_q_bit
);
   // One extra bit on the shifted value so the compare never wraps.
   logic [WIDTH+1:0] w_shifted;

   assign w_shifted = {i_rem, i_bit};
   assign o_q_bit   = (w_shifted >= {2'b00, i_b_mag});
   // The remainder always stays below |b|, so it fits back into WIDTH+1 bits.
   assign o_rem     = o_q_bit ? (WIDTH+1)'(w_shifted - {2'b00, i_b_mag})
                              : (WIDTH+1)'(w_shifted);
endmodule

// File: rtl/fixed_div.sv
// -----------------------------------------------------------------------------
// fixed_div
// Sequential signed Q8.24 divider, q = (a << FRAC) / b, one quotient bit per
// clock, truncating toward zero and saturating to the signed range.
//   Clk      : system clock, rising edge
//   Reset    : asynchronous active-high reset
//   start    : request, sampled only in IDLE
//   a, b     : signed dividend / divisor, captured when start is accepted
//   busy     : operation in progress
//   done     : one-cycle pulse, q and flags valid from this cycle on
//   q        : signed quotient, held until the next done
//   div_zero : last operation had b == 0
//   overflow : last quotient saturated
// -----------------------------------------------------------------------------
module fixed_div
   import fixed_pkg::*;
#(
   parameter int WIDTH = fixed_pkg::WIDTH,
   parameter int FRAC  = fixed_pkg::FRAC
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic             div_zero,
   output logic             overflow
);
   localparam int N     = WIDTH + FRAC;
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);
   localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       r_state;
   logic [N-1:0]     r_dividend;
   logic [N-1:0]     r_quo;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_b_mag;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sign;
   logic             r_a_neg;
   logic             r_bz;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_q;
   logic             r_div_zero;
   logic             r_overflow;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_rem_next;
   logic             w_q_bit;
   logic             w_sat_pos;
   logic             w_sat_neg;
   logic             w_sat;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   assign w_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
   assign w_b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem   (r_rem),
      .i_bit   (r_dividend[N-1]),
      .i_b_mag (r_b_mag),
      .o_rem   (w_rem_next),
      .o_q_bit (w_q_bit)
   );

   // Positive results may reach 2^(WIDTH-1)-1, negative ones exactly 2^(WIDTH-1).
   assign w_sat_pos = |r_quo[N-1:WIDTH-1];
   assign w_sat_neg = (|r_quo[N-1:WIDTH]) | (r_quo[WIDTH-1] & (|r_quo[WIDTH-2:0]));
   assign w_sat     = r_sign ? w_sat_neg : w_sat_pos;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_dividend <= '0;
         r_quo      <= '0;
         r_rem      <= '0;
         r_b_mag    <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_a_neg    <= 1'b0;
         r_bz       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_q        <= '0;
         r_div_zero <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // The done cycle is a recovery cycle: a held start is taken on
               // the following edge, giving one result every N+3 cycles.
               if (start && !r_done) begin
                  r_sign     <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_a_neg    <= a[WIDTH-1];
                  r_b_mag    <= w_b_mag;
                  r_dividend <= {w_a_mag, {FRAC{1'b0}}};
                  r_rem      <= '0;
                  r_quo      <= '0;
                  r_cnt      <= '0;
                  r_bz       <= (b == '0);
                  r_div_zero <= 1'b0;
                  r_overflow <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= (b == '0) ? FINISH : CALC;
               end
            end
            CALC: begin
               r_rem      <= w_rem_next;
               r_quo      <= {r_quo[N-2:0], w_q_bit};
               r_dividend <= {r_dividend[N-2:0], 1'b0};
               r_cnt      <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= FINISH;
               end
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= IDLE;
               if (r_bz) begin
                  r_q        <= r_a_neg ? L_MIN : L_MAX;
                  r_div_zero <= 1'b1;
               end else if (w_sat) begin
                  r_q        <= r_sign ? L_MIN : L_MAX;
                  r_overflow <= 1'b1;
               end else begin
                  r_q <= r_sign ? (~r_quo[WIDTH-1:0] + 1'b1) : r_quo[WIDTH-1:0];
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign q        = r_q;
   assign div_zero = r_div_zero;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_fixed_div.sv
module tb_fixed_div;
   logic        Clk;
   logic        Reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic        div_zero;
   logic        overflow;

   fixed_div dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .div_zero (div_zero),
      .overflow (overflow)
   );

   typedef struct {
      logic [31:0] q;
      logic        dz;
      logic        ov;
      int          issue;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endfunction

   // Monitor: pops one expected response per done pulse.
   always @(negedge Clk) begin
      if (!Reset && done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_q"},        q,        e.q);
            check({e.name, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
            check({e.name, "_overflow"}, {31'd0, overflow}, {31'd0, e.ov});
            check({e.name, "_busy_low"}, {31'd0, busy}, 32'd0);
            check({e.name, "_latency"},  32'(cyc - e.issue + 1), 32'(e.lat));
            $display("op %-10s q=0x%08h dz=%0b ov=%0b latency=%0d", e.name, q, div_zero,
                     overflow, cyc - e.issue + 1);
         end
      end
   end

   task automatic wait_idle();
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge Clk); #1;
         if (!busy && !done) break;
      end
      if (k == 200) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_done(input int prev);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge Clk); #1;
         if (n_done > prev) break;
      end
      if (k == 200) check("done_timeout", 32'd1, 32'd0);
   endtask

   // Issue one start pulse; the next rising edge is the accepting edge.
   task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] eq,
                        input logic edz, input logic eov, input int lat, input string name);
      exp_t e;
      a = ta; b = tb; start = 1'b1;
      e.q = eq; e.dz = edz; e.ov = eov; e.issue = cyc + 1; e.lat = lat; e.name = name;
      sb.push_back(e);
      @(negedge Clk);
      start = 1'b0;
      check({name, "_busy_high"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] eq,
                         input logic edz, input logic eov, input int lat, input string name);
      int prev;
      wait_idle();
      prev = n_done;
      issue(ta, tb, eq, edz, eov, lat, name);
      wait_done(prev);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      Reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_q", q, 32'd0);
      check("reset_flags", {30'd0, div_zero, overflow}, 32'd0);

      run_op(32'h06B40000, 32'h02100000, 32'h03400000, 1'b0, 1'b0, 58, "pos_pos");
      run_op(32'hF94C0000, 32'h02100000, 32'hFCC00000, 1'b0, 1'b0, 58, "neg_pos");
      run_op(32'hF94C0000, 32'hFDF00000, 32'h03400000, 1'b0, 1'b0, 58, "neg_neg");
      run_op(32'h01000000, 32'h03000000, 32'h00555555, 1'b0, 1'b0, 58, "third");
      run_op(32'hFF000000, 32'h03000000, 32'hFFAAAAAB, 1'b0, 1'b0, 58, "neg_third");
      run_op(32'h01000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2,  "dz_pos");
      run_op(32'hFF000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 2,  "dz_neg");
      run_op(32'h00000000, 32'h03000000, 32'h00000000, 1'b0, 1'b0, 58, "zero_num");
      run_op(32'h7F000000, 32'h00800000, 32'h7FFFFFFF, 1'b0, 1'b1, 58, "ovf_pos");
      run_op(32'h80000000, 32'h01000000, 32'h80000000, 1'b0, 1'b0, 58, "min_exact");

      // Start pulses while busy must be ignored.
      wait_idle();
      prev = n_done;
      issue(32'h01000000, 32'h03000000, 32'h00555555, 1'b0, 1'b0, 58, "busy_ign");
      for (int i = 0; i < 5; i++) begin
         repeat (4) @(negedge Clk);
         a = 32'h7F000000; b = 32'h00800000; start = 1'b1;
         @(negedge Clk);
         start = 1'b0;
      end
      wait_done(prev);
      prev = n_done;
      repeat (70) @(negedge Clk);
      check("busy_ign_no_extra", 32'(n_done - prev), 32'd0);

      // Start held high: results every 59 cycles.
      wait_idle();
      prev = n_done;
      a = 32'h06B40000; b = 32'h02100000; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.q = 32'h03400000; e.dz = 1'b0; e.ov = 1'b0;
         e.issue = cyc + 1 + 59 * i; e.lat = 58; e.name = $sformatf("held%0d", i);
         sb.push_back(e);
      end
      for (int i = 0; i < 3; i++) wait_done(prev + i);
      start = 1'b0;
      repeat (3) @(negedge Clk);
      check("held_count", 32'(n_done - prev), 32'd3);

      // Reset in the middle of CALC.
      wait_idle();
      prev = n_done;
      a = 32'hF94C0000; b = 32'h02100000; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      repeat (20) @(negedge Clk);
      Reset = 1'b1;
      #1;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_q", q, 32'd0);
      check("midreset_flags", {30'd0, div_zero, overflow}, 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (70) @(negedge Clk);
      check("midreset_no_done", 32'(n_done - prev), 32'd0);
      check("midreset_q_after", q, 32'd0);

      run_op(32'h01000000, 32'h03000000, 32'h00555555, 1'b0, 1'b0, 58, "post_reset");
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
